// File: rtl/lockin_cfg_bank.sv
// Configuration register bank on the PS GPIO bus: byte-wise shadow assembly,
// atomic commit to live registers, readback and a sticky address-error flag.
module lockin_cfg_bank #(
   parameter int          NUM_REGS    = 8,
   parameter int          SYNC_STAGES = 2,
   parameter logic [31:0] RST_VAL     = 32'h0000_0000,
   parameter logic [15:0] COMMIT_ADDR = 16'hFFFF
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic [31:0]           gpio_in,
   output logic [31:0]           gpio_out,
   output logic [32*NUM_REGS-1:0] regs_o,
   output logic                  commit_o,
   output logic                  err_o
);

   localparam logic [13:0] NUM_IDX  = 14'(NUM_REGS);
   localparam logic [7:0]  NUM_BYTE = 8'(NUM_REGS);

   logic [25:0] sync_r [SYNC_STAGES];
   logic [31:0] shadow_r [NUM_REGS];
   logic [31:0] live_r [NUM_REGS];
   logic        w_prev_r;
   logic        r_prev_r;

   logic [25:0] word_s;
   logic [15:0] addr_s;
   logic [7:0]  data_s;
   logic [13:0] idx_s;
   logic [1:0]  lane_s;
   logic        w_edge_s;
   logic        r_edge_s;
   logic        is_ctrl_s;
   logic        in_range_s;
   logic        err_set_s;
   logic        err_clr_s;
   logic [31:0] rd_live_s;
   logic        unused_s;

   assign unused_s   = ^gpio_in[31:26];
   assign word_s     = sync_r[SYNC_STAGES-1];
   assign addr_s     = word_s[15:0];
   assign data_s     = word_s[23:16];
   assign idx_s      = addr_s[15:2];
   assign lane_s     = addr_s[1:0];
   assign w_edge_s   = word_s[24] & ~w_prev_r;
   assign r_edge_s   = word_s[25] & ~r_prev_r;
   assign is_ctrl_s  = (addr_s == COMMIT_ADDR);
   assign in_range_s = (idx_s < NUM_IDX);

   // Synchroniser chain and previous-strobe flops for edge detection.
   always_ff @(posedge clk) begin
      if (rst) begin
         for (int i = 0; i < SYNC_STAGES; i++) sync_r[i] <= 26'd0;
         w_prev_r <= 1'b0;
         r_prev_r <= 1'b0;
      end else begin
         sync_r[0] <= gpio_in[25:0];
         for (int i = 1; i < SYNC_STAGES; i++) sync_r[i] <= sync_r[i-1];
         w_prev_r <= word_s[24];
         r_prev_r <= word_s[25];
      end
   end

   // Error flag set/clear decode and live-register read mux.
   always_comb begin
      err_set_s = ~is_ctrl_s & ~in_range_s & (w_edge_s | r_edge_s);
      err_clr_s = w_edge_s & is_ctrl_s & data_s[1];
      rd_live_s = 32'h0000_0000;
      for (int k = 0; k < NUM_REGS; k++) begin
         rd_live_s = (idx_s == 14'(k)) ? live_r[k] : rd_live_s;
      end
   end

   // Shadow/live registers, commit pulse, error flag and readback register.
   always_ff @(posedge clk) begin
      if (rst) begin
         for (int k = 0; k < NUM_REGS; k++) begin
            shadow_r[k] <= RST_VAL;
            live_r[k]   <= RST_VAL;
         end
         gpio_out <= 32'h0000_0000;
         commit_o <= 1'b0;
         err_o    <= 1'b0;
      end else begin
         commit_o <= w_edge_s & is_ctrl_s & data_s[0];
         if (w_edge_s && is_ctrl_s) begin
            // Reload precedes commit, so a combined reload+commit leaves live as is.
            for (int k = 0; k < NUM_REGS; k++) begin
               if (data_s[2]) shadow_r[k] <= live_r[k];
               if (data_s[0]) live_r[k] <= data_s[2] ? live_r[k] : shadow_r[k];
            end
         end else if (w_edge_s && in_range_s) begin
            for (int k = 0; k < NUM_REGS; k++) begin
               if (idx_s == 14'(k)) begin
                  case (lane_s)
                     2'd0:    shadow_r[k][7:0]   <= data_s;
                     2'd1:    shadow_r[k][15:8]  <= data_s;
                     2'd2:    shadow_r[k][23:16] <= data_s;
                     2'd3:    shadow_r[k][31:24] <= data_s;
                     default: shadow_r[k]        <= shadow_r[k];
                  endcase
               end
            end
         end
         if (err_set_s)      err_o <= 1'b1;
         else if (err_clr_s) err_o <= 1'b0;
         if (r_edge_s) begin
            if (is_ctrl_s)       gpio_out <= {NUM_BYTE, 15'd0, err_o, 8'h00};
            else if (in_range_s) gpio_out <= rd_live_s;
            else                 gpio_out <= 32'hDEAD_BEEF;
         end
      end
   end

   for (genvar k = 0; k < NUM_REGS; k++) begin : g_out
      assign regs_o[32*k +: 32] = live_r[k];
   end

endmodule

// File: tb/tb_lockin_cfg_bank.sv
// Directed bench for lockin_cfg_bank with default parameters (8 regs, 2 sync stages).
module tb_lockin_cfg_bank;

   logic         clk = 1'b0;
   logic         rst;
   logic [31:0]  gpio_in;
   logic [31:0]  gpio_out;
   logic [255:0] regs_o;
   logic         commit_o;
   logic         err_o;

   int checks = 0;
   int errors = 0;
   int pulses = 0;
   logic [255:0] exp_regs;

   always #5 clk = ~clk;

   lockin_cfg_bank #(
      .NUM_REGS(8), .SYNC_STAGES(2), .RST_VAL(32'h0000_0000), .COMMIT_ADDR(16'hFFFF)
   ) dut (
      .clk(clk), .rst(rst), .gpio_in(gpio_in), .gpio_out(gpio_out),
      .regs_o(regs_o), .commit_o(commit_o), .err_o(err_o)
   );

   task automatic tick();
      @(posedge clk);
      #1;
      if (commit_o) pulses++;
   endtask

   // One full protocol event: strobes high 3 clocks, low 3 clocks.
   task automatic strobe(input logic [15:0] a, input logic [7:0] d, input logic w, input logic r);
      pulses = 0;
      gpio_in = {6'd0, r, w, d, a};
      repeat (3) tick();
      gpio_in[25:24] = 2'b00;
      repeat (3) tick();
   endtask

   task automatic test_reset();
      rst = 1'b1;
      gpio_in = 32'd0;
      repeat (4) tick();
      checks++; if (regs_o !== 256'd0) begin errors++; $display("FAIL reset_regs got %h exp 0", regs_o); end
      checks++; if (gpio_out !== 32'd0) begin errors++; $display("FAIL reset_gpio_out got %h exp 0", gpio_out); end
      checks++; if (commit_o !== 1'b0) begin errors++; $display("FAIL reset_commit got %b exp 0", commit_o); end
      checks++; if (err_o !== 1'b0) begin errors++; $display("FAIL reset_err got %b exp 0", err_o); end
      rst = 1'b0;
      tick();
   endtask

   task automatic test_byte_commit();
      strobe(16'h0008, 8'h78, 1'b1, 1'b0);
      strobe(16'h0009, 8'h56, 1'b1, 1'b0);
      strobe(16'h000A, 8'h34, 1'b1, 1'b0);
      strobe(16'h000B, 8'h12, 1'b1, 1'b0);
      checks++; if (regs_o !== 256'd0) begin errors++; $display("FAIL shadow_not_live got %h exp 0", regs_o); end
      gpio_in = {6'd0, 2'b01, 8'h01, 16'hFFFF};
      tick(); tick();
      checks++; if (commit_o !== 1'b0 || regs_o[95:64] !== 32'd0) begin
         errors++; $display("FAIL commit_early got commit=%b reg2=%h exp 0/0", commit_o, regs_o[95:64]); end
      tick();
      checks++; if (commit_o !== 1'b1 || regs_o[95:64] !== 32'h1234_5678) begin
         errors++; $display("FAIL commit_at_3 got commit=%b reg2=%h exp 1/12345678", commit_o, regs_o[95:64]); end
      tick();
      checks++; if (commit_o !== 1'b0) begin errors++; $display("FAIL commit_width got %b exp 0", commit_o); end
      gpio_in[24] = 1'b0;
      repeat (3) tick();
   endtask

   task automatic test_atomic();
      for (int i = 0; i < 4; i++) strobe(16'(i), 8'hAA, 1'b1, 1'b0);
      for (int i = 0; i < 4; i++) strobe(16'h001C + 16'(i), 8'h55, 1'b1, 1'b0);
      gpio_in = {6'd0, 2'b01, 8'h01, 16'hFFFF};
      tick(); tick();
      checks++; if (regs_o[31:0] !== 32'd0 || regs_o[255:224] !== 32'd0) begin
         errors++; $display("FAIL atomic_before got r0=%h r7=%h exp 0/0", regs_o[31:0], regs_o[255:224]); end
      tick();
      checks++; if (regs_o[31:0] !== 32'hAAAA_AAAA || regs_o[255:224] !== 32'h5555_5555) begin
         errors++; $display("FAIL atomic_after got r0=%h r7=%h exp aaaaaaaa/55555555", regs_o[31:0], regs_o[255:224]); end
      gpio_in[24] = 1'b0;
      repeat (3) tick();
      strobe(16'h0000, 8'h11, 1'b1, 1'b0);
      strobe(16'hFFFF, 8'h04, 1'b1, 1'b0);
      strobe(16'hFFFF, 8'h01, 1'b1, 1'b0);
      checks++; if (regs_o[31:0] !== 32'hAAAA_AAAA) begin errors++; $display("FAIL reload_discard got %h exp aaaaaaaa", regs_o[31:0]); end
      checks++; if (pulses !== 1) begin errors++; $display("FAIL commit_count got %0d exp 1", pulses); end
      strobe(16'h0001, 8'h22, 1'b1, 1'b0);
      strobe(16'hFFFF, 8'h05, 1'b1, 1'b0);
      checks++; if (pulses !== 1) begin errors++; $display("FAIL ctrl05_pulse got %0d exp 1", pulses); end
      checks++; if (regs_o[31:0] !== 32'hAAAA_AAAA) begin errors++; $display("FAIL ctrl05_live got %h exp aaaaaaaa", regs_o[31:0]); end
      strobe(16'hFFFF, 8'h01, 1'b1, 1'b0);
      checks++; if (regs_o[31:0] !== 32'hAAAA_AAAA) begin errors++; $display("FAIL ctrl05_shadow got %h exp aaaaaaaa", regs_o[31:0]); end
      checks++; if (regs_o[95:64] !== 32'h1234_5678) begin errors++; $display("FAIL reg2_kept got %h exp 12345678", regs_o[95:64]); end
   endtask

   task automatic test_error();
      exp_regs = 256'd0;
      exp_regs[31:0]    = 32'hAAAA_AAAA;
      exp_regs[95:64]   = 32'h1234_5678;
      exp_regs[255:224] = 32'h5555_5555;
      strobe(16'h0020, 8'hFF, 1'b1, 1'b0);
      checks++; if (err_o !== 1'b1) begin errors++; $display("FAIL err_write got %b exp 1", err_o); end
      strobe(16'hFFFF, 8'h01, 1'b1, 1'b0);
      checks++; if (regs_o !== exp_regs) begin errors++; $display("FAIL err_regs got %h exp %h", regs_o, exp_regs); end
      strobe(16'h0020, 8'h00, 1'b0, 1'b1);
      checks++; if (gpio_out !== 32'hDEAD_BEEF) begin errors++; $display("FAIL err_read got %h exp deadbeef", gpio_out); end
      strobe(16'hFFFF, 8'h00, 1'b0, 1'b1);
      checks++; if (gpio_out !== 32'h0800_0100) begin errors++; $display("FAIL status_err got %h exp 08000100", gpio_out); end
      strobe(16'hFFFF, 8'h02, 1'b1, 1'b0);
      checks++; if (err_o !== 1'b0) begin errors++; $display("FAIL err_clear got %b exp 0", err_o); end
      strobe(16'hFFFF, 8'h00, 1'b0, 1'b1);
      checks++; if (gpio_out !== 32'h0800_0000) begin errors++; $display("FAIL status_clr got %h exp 08000000", gpio_out); end
      strobe(16'h0008, 8'h00, 1'b0, 1'b1);
      checks++; if (gpio_out !== 32'h1234_5678) begin errors++; $display("FAIL read_reg2 got %h exp 12345678", gpio_out); end
   endtask

   task automatic test_strobe_rules();
      gpio_in = {6'd0, 2'b01, 8'h11, 16'h000C};
      repeat (5) tick();
      gpio_in[23:16] = 8'h22;
      repeat (5) tick();
      gpio_in[24] = 1'b0;
      repeat (3) tick();
      strobe(16'hFFFF, 8'h01, 1'b1, 1'b0);
      checks++; if (regs_o[127:96] !== 32'h0000_0011) begin errors++; $display("FAIL held_strobe got %h exp 00000011", regs_o[127:96]); end
      strobe(16'h0004, 8'hA5, 1'b1, 1'b0);
      strobe(16'hFFFF, 8'h01, 1'b1, 1'b0);
      strobe(16'h0004, 8'h99, 1'b1, 1'b0);
      strobe(16'h0005, 8'h77, 1'b1, 1'b1);
      checks++; if (gpio_out !== 32'h0000_00A5) begin errors++; $display("FAIL rw_same_word got %h exp 000000a5", gpio_out); end
      strobe(16'hFFFF, 8'h01, 1'b1, 1'b0);
      strobe(16'h0004, 8'h00, 1'b0, 1'b1);
      checks++; if (gpio_out !== 32'h0000_7799 || regs_o[63:32] !== 32'h0000_7799) begin
         errors++; $display("FAIL rw_after_commit got rd=%h reg1=%h exp 00007799", gpio_out, regs_o[63:32]); end
   endtask

   task automatic test_reset_mid();
      strobe(16'h0010, 8'hCC, 1'b1, 1'b0);
      strobe(16'h0011, 8'hDD, 1'b1, 1'b0);
      rst = 1'b1;
      repeat (2) tick();
      rst = 1'b0;
      strobe(16'hFFFF, 8'h01, 1'b1, 1'b0);
      checks++; if (regs_o !== 256'd0) begin errors++; $display("FAIL mid_reset_regs got %h exp 0", regs_o); end
      checks++; if (gpio_out !== 32'd0) begin errors++; $display("FAIL mid_reset_gpio got %h exp 0", gpio_out); end
      strobe(16'h0014, 8'h33, 1'b1, 1'b0);
      pulses = 0;
      gpio_in = {6'd0, 2'b01, 8'h01, 16'hFFFF};
      tick();
      rst = 1'b1;
      gpio_in = 32'd0;
      repeat (3) tick();
      rst = 1'b0;
      repeat (6) tick();
      checks++; if (pulses !== 0) begin errors++; $display("FAIL lost_commit got %0d pulses exp 0", pulses); end
      checks++; if (regs_o[191:160] !== 32'd0) begin errors++; $display("FAIL lost_commit_reg5 got %h exp 0", regs_o[191:160]); end
   endtask

   initial begin
      test_reset();
      test_byte_commit();
      test_atomic();
      test_error();
      test_strobe_rules();
      test_reset_mid();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/lockin_cfg_bank.md
# lockin_cfg_bank

Parametrised configuration register bank for the lock-in top level. It replaces the per-address single-register GPIO decoders with one block holding NUM_REGS 32-bit registers behind the same 32-bit PS GPIO bus. The bank assembles registers byte by byte into shadow copies and commits all of them to the live outputs in a single cycle, so the NCO increment, scalar and mux settings never change half-written. It also provides GPIO readback and a sticky address-error flag; it sits between the PS GPIO and the opo_locking/mul/out_mux datapath.

## Interface
- NUM_REGS, 8, number of 32-bit registers (1..64)
- SYNC_STAGES, 2, synchroniser depth on gpio_in (2..4)
- RST_VAL, 32'h0000_0000, reset value of every shadow and live register
- COMMIT_ADDR, 16'hFFFF, GPIO address of the control word
- clk  in  1  system clock
- rst  in  1  synchronous, active-high reset
- gpio_in  in  32  [15:0] addr, [23:16] data byte, [24] w_clk write strobe, [25] r_clk read strobe, [31:26] ignored
- gpio_out  out  32  readback word
- regs_o  out  32*NUM_REGS  live registers; register k at [32k+31:32k]
- commit_o  out  1  one-cycle pulse when live registers are updated
- err_o  out  1  sticky error: write or read to an index ≥ NUM_REGS

## Operation
- Addressing: for addr ≠ COMMIT_ADDR, register index = addr[15:2] and byte lane = addr[1:0], with lane 0 = bits [7:0].
- All of gpio_in[25:0] passes through a SYNC_STAGES flop chain. A prev-stage flop on the synchronised w_clk and r_clk detects rising edges. Addr and data are taken from the same synchronised word as the edge, so they are always coherent with it.
- Write edge, addr ≠ COMMIT_ADDR, index < NUM_REGS: the shadow[index] byte at the addressed lane is loaded with data. Other bytes are unchanged. Live registers are unchanged.
- Write edge, index ≥ NUM_REGS: no register changes; err_o is set.
- Write edge, addr = COMMIT_ADDR, data bit0 = 1: all live registers are loaded from shadow in the same cycle, and commit_o pulses once.
- Write edge, addr = COMMIT_ADDR, data bit1 = 1: err_o is cleared.
- Write edge, addr = COMMIT_ADDR, data bit2 = 1: every shadow register is reloaded from its live value, discarding uncommitted writes.
- Control-word bit order, when several bits are set in one write: bit2 reload happens before bit0 commit, so a 0x05 write leaves live unchanged but still pulses commit_o. Bit1 clear and a new error cannot arise in the same write.
- Read edge: gpio_out is loaded with the live register at index addr[15:2] and holds until the next read edge.
  - A read with index ≥ NUM_REGS returns 32'hDEAD_BEEF and sets err_o.
  - A read at COMMIT_ADDR returns {NUM_REGS[7:0], 15'b0, err_o, 8'h00}, with err_o at bit 8.
- Simultaneous read and write edges in one synchronised word: the write is applied and the read returns the live value from before that write or commit.
- Only rising edges act. A held-high strobe is one event. The strobe must go low for at least one synchronised cycle before the next event.

## Timing
- Reset values: gpio_out = 0, commit_o = 0, err_o = 0, regs_o = all RST_VAL, shadow = RST_VAL, synchroniser and edge flops = 0.
- gpio_in changing before clock edge E0 is first seen at synchroniser stage 1 at E0. The edge is detected after E(SYNC_STAGES-1).
- Shadow, live, err_o and gpio_out all update at E(SYNC_STAGES). That is 3 clocks for SYNC_STAGES = 2.
- commit_o is high for exactly the cycle following E(SYNC_STAGES), coincident with the new regs_o.
- Reset asserted mid-sequence:
  - Partially written shadows revert to RST_VAL.
  - A commit edge that is in the synchroniser when rst is asserted is lost.
  - No commit_o pulse is issued while rst = 1.
- Maximum event rate is one write or read per 2·(SYNC_STAGES+1) clocks. Faster toggling is outside the specified protocol.

## Test plan
- Reset: hold rst 4 cycles -> regs_o all 0, gpio_out 0, commit_o 0, err_o 0.
- Byte assembly plus commit: write reg 2 lanes 0..3 with 0x78, 0x56, 0x34, 0x12 -> regs_o[95:64] stays 0 until a COMMIT_ADDR write with data 0x01 -> regs_o[95:64] = 0x12345678, with commit_o one cycle high exactly 3 clocks after the strobe edge.
- Atomicity: stage reg 0 = 0xAAAA_AAAA and reg 7 = 0x5555_5555, then commit -> both change in the same cycle. Next, write a reg 0 lane and send control data 0x04 -> reg 0 is unchanged after a later commit.
- Error path with NUM_REGS = 8:
  - Write addr 0x0020 (index 8) -> err_o = 1, regs_o unchanged.
  - Read addr 0x0020 -> gpio_out = 0xDEADBEEF.
  - Read COMMIT_ADDR -> gpio_out = 0x0800_0100.
  - Control write with data 0x02 -> err_o = 0.
- Strobe edge rules: hold w_clk high 10 cycles -> exactly one byte write. Set w_clk and r_clk in the same word to reg 1 with a commit pending -> gpio_out shows the pre-commit value.
- Mid-operation reset: write two lanes, pulse rst, then commit -> regs_o reg all RST_VAL. A commit strobe issued 1 cycle before rst produces no commit_o.
